// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg
// Shared definitions for the 8:1 mux scan controller: FSM state encoding,
// select/channel/data widths and an even-parity helper.
// No ports (package).
package mux_scan_pkg;

    localparam int SEL_W  = 3;
    localparam int NUM_CH = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Even parity bit: XOR of all data bits, so data plus parity has an even
    // number of ones.
    function automatic logic even_parity(input logic [DATA_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// mux_scan_dwell_cnt
// Counts the cycles a select code has been held. Counts 0..DWELL-1 and wraps;
// tc is high during the last cycle of each dwell period.
// Ports:
//   clk  in   clock, rising edge
//   rst  in   synchronous active-high reset
//   clr  in   synchronous clear (held while the controller is not scanning)
//   tc   out  terminal count: current cycle is the last of the dwell
module mux_scan_dwell_cnt
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tc
);

    localparam logic [7:0] CNT_MAX = 8'(DWELL - 1);

    logic [7:0] cnt;

    assign tc = (cnt == CNT_MAX);

    // Dwell cycle counter, cleared outside SCAN and wrapped on terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (clr) begin
            cnt <= 8'd0;
        end else if (tc) begin
            cnt <= 8'd0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
// Steps the select lines of an external 8:1 mux through codes 0..7, holding
// each code DWELL cycles and sampling the mux output y on the last cycle of
// each dwell. After code 7 the full word is loaded into data, the FSM spends
// one cycle in DONE (select 0) and valid pulses for the cycle after DONE.
// Optional feature: define MUX_SCAN_PARITY_EN to add the parity output.
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   start       in   scan request, honoured only in IDLE
//   continuous  in   restart immediately after a scan completes
//   y           in   output of the external mux
//   s0,s1,s2    out  registered mux select (s2 = MSB)
//   data        out  captured word, bit k = mux input k
//   valid       out  one-cycle pulse marking a new data word
//   busy        out  high whenever not in IDLE
//   parity      out  even parity of data (MUX_SCAN_PARITY_EN only)
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    input  logic              y,
    output logic              s0,
    output logic              s1,
    output logic              s2,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              busy
`ifdef MUX_SCAN_PARITY_EN
    ,
    output logic              parity
`endif
);

    state_t             state;
    logic [SEL_W-1:0]   sel;
    logic [DATA_W-1:0]  capture;
    logic [DATA_W-1:0]  word_next;
    logic               dwell_clr;
    logic               dwell_tc;
`ifdef MUX_SCAN_PARITY_EN
    logic               parity_reg;
`endif

    // The counter only runs while scanning, so every dwell starts from zero.
    assign dwell_clr = (state != SCAN);

    mux_scan_dwell_cnt #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk (clk),
        .rst (rst),
        .clr (dwell_clr),
        .tc  (dwell_tc)
    );

    // Completed word on the code-7 sample: earlier captures plus the live y.
    assign word_next = {y, capture[NUM_CH-2:0]};

    assign s0    = sel[0];
    assign s1    = sel[1];
    assign s2    = sel[2];
`ifdef MUX_SCAN_PARITY_EN
    assign parity = parity_reg;
`endif

    // Scan FSM with registered select, capture, data, valid and busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sel     <= 3'd0;
            capture <= 8'd0;
            data    <= 8'd0;
            valid   <= 1'b0;
            busy    <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            parity_reg <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    valid <= 1'b0;
                    sel   <= 3'd0;
                    if (start) begin
                        state <= SCAN;
                        busy  <= 1'b1;
                    end else begin
                        busy  <= 1'b0;
                    end
                end
                SCAN: begin
                    valid <= 1'b0;
                    busy  <= 1'b1;
                    if (dwell_tc) begin
                        capture[sel] <= y;
                        // Code 7 is the last sample: publish the word and
                        // return the select to 0 for the DONE cycle.
                        if (sel == 3'd7) begin
                            data  <= word_next;
`ifdef MUX_SCAN_PARITY_EN
                            parity_reg <= even_parity(word_next);
`endif
                            sel   <= 3'd0;
                            state <= DONE;
                        end else begin
                            sel   <= sel + 3'd1;
                        end
                    end
                end
                DONE: begin
                    // valid appears in the cycle following DONE.
                    valid <= 1'b1;
                    sel   <= 3'd0;
                    if (continuous) begin
                        state <= SCAN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    sel   <= 3'd0;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl
// Two instances (DWELL=2 and DWELL=1) driven by directed and random stimulus,
// each checked every cycle against a timeline-based reference model, plus
// directed latency/interval checks.
module tb_mux_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       continuous = 1'b0;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [7:0] mux_a = 8'd0;
    logic [7:0] mux_b = 8'd0;

    logic       s0_a, s1_a, s2_a, valid_a, busy_a, y_a;
    logic       s0_b, s1_b, s2_b, valid_b, busy_b, y_b;
    logic [7:0] data_a, data_b;
`ifdef MUX_SCAN_PARITY_EN
    logic       par_a, par_b;
`endif

    assign y_a = mux_a[{s2_a, s1_a, s0_a}];
    assign y_b = mux_b[{s2_b, s1_b, s0_b}];

    mux_scan_ctrl #(.DWELL(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .continuous(continuous), .y(y_a),
        .s0(s0_a), .s1(s1_a), .s2(s2_a), .data(data_a), .valid(valid_a), .busy(busy_a)
`ifdef MUX_SCAN_PARITY_EN
        , .parity(par_a)
`endif
    );

    mux_scan_ctrl #(.DWELL(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .continuous(continuous), .y(y_b),
        .s0(s0_b), .s1(s1_b), .s2(s2_b), .data(data_b), .valid(valid_b), .busy(busy_b)
`ifdef MUX_SCAN_PARITY_EN
        , .parity(par_b)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: t counts cycles since the scan began; code k occupies
    // cycles k*D .. k*D+D-1, t == 8*D is the DONE cycle.
    typedef struct {
        bit         busy;
        int         t;
        logic [7:0] cap;
        logic [7:0] data;
        bit         valid;
    } model_t;

    function automatic model_t step(input model_t m, input int d, input bit r,
                                    input bit st, input bit cont, input logic [7:0] mi);
        model_t n;
        int     k;
        n = m;
        k = m.t / d;
        if (r) begin
            n.busy = 1'b0; n.t = 0; n.cap = 8'd0; n.data = 8'd0; n.valid = 1'b0;
        end else begin
            n.valid = 1'b0;
            if (!m.busy) begin
                if (st) begin
                    n.busy = 1'b1;
                    n.t    = 0;
                end
            end else if (m.t < 8 * d) begin
                n.t = m.t + 1;
                if (n.t % d == 0) begin
                    n.cap[k] = mi[k];
                    if (n.t == 8 * d) n.data = n.cap;
                end
            end else begin
                n.valid = 1'b1;
                n.t     = 0;
                if (!cont) n.busy = 1'b0;
            end
        end
        return n;
    endfunction

    function automatic int exp_sel(input model_t m, input int d);
        return (m.busy && m.t < 8 * d) ? m.t / d : 0;
    endfunction

    model_t ma = '{busy: 1'b0, t: 0, cap: 8'd0, data: 8'd0, valid: 1'b0};
    model_t mb = '{busy: 1'b0, t: 0, cap: 8'd0, data: 8'd0, valid: 1'b0};

    always @(posedge clk) begin
        ma <= step(ma, 2, rst, start_a, continuous, mux_a);
        mb <= step(mb, 1, rst, start_b, continuous, mux_b);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("sel_a",   {29'd0, s2_a, s1_a, s0_a}, 32'(exp_sel(ma, 2)));
            check("busy_a",  {31'd0, busy_a},  {31'd0, ma.busy});
            check("valid_a", {31'd0, valid_a}, {31'd0, ma.valid});
            check("data_a",  {24'd0, data_a},  {24'd0, ma.data});
            check("sel_b",   {29'd0, s2_b, s1_b, s0_b}, 32'(exp_sel(mb, 1)));
            check("busy_b",  {31'd0, busy_b},  {31'd0, mb.busy});
            check("valid_b", {31'd0, valid_b}, {31'd0, mb.valid});
            check("data_b",  {24'd0, data_b},  {24'd0, mb.data});
`ifdef MUX_SCAN_PARITY_EN
            check("par_a",   {31'd0, par_a},   {31'd0, ^ma.data});
            check("par_b",   {31'd0, par_b},   {31'd0, ^mb.data});
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int cnt;
    int pulses;

    initial begin
        // Reset
        tick(); tick();
        chk_en = 1'b1;
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_data", {24'd0, data_a}, 32'd0);
        rst = 1'b0;

        // DWELL=2, inputs 0,1,0,1,... -> 8'hAA, valid 17 cycles after start
        mux_a = 8'hAA;
        start_a = 1'b1; tick(); start_a = 1'b0;
        cnt = 0;
        while (!valid_a && cnt < 100) begin tick(); cnt++; end
        check("aa_latency", cnt, 32'd17);
        check("aa_data", {24'd0, data_a}, 32'h0000_00AA);
        check("aa_busy_fall", {31'd0, busy_a}, 32'd0);
        tick();
        check("aa_valid_width", {31'd0, valid_a}, 32'd0);

        // start re-pulsed at select 3 -> one valid, no restart
        start_a = 1'b1; tick(); start_a = 1'b0;
        cnt = 0;
        while ({s2_a, s1_a, s0_a} != 3'd3 && cnt < 100) begin tick(); cnt++; end
        check("sel3_reached", {31'd0, (cnt < 100)}, 32'd1);
        start_a = 1'b1; tick(); start_a = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin tick(); if (valid_a) pulses++; end
        check("restart_pulses", pulses, 32'd1);

        // Continuous scans of all-ones: 17 cycles apart
        mux_a = 8'hFF; continuous = 1'b1;
        start_a = 1'b1; tick(); start_a = 1'b0;
        cnt = 0;
        while (!valid_a && cnt < 100) begin tick(); cnt++; end
        check("cont_first", cnt, 32'd17);
        for (int p = 0; p < 3; p++) begin
            cnt = 0;
            tick(); cnt++;
            while (!valid_a && cnt < 100) begin tick(); cnt++; end
            check("cont_interval", cnt, 32'd17);
            check("cont_data", {24'd0, data_a}, 32'h0000_00FF);
        end
        continuous = 1'b0;
        cnt = 0;
        while (busy_a && cnt < 40) begin tick(); cnt++; end
        check("cont_stop_idle", {31'd0, busy_a}, 32'd0);

        // Reset at select 4 aborts scan, data stays 0, no valid
        rst = 1'b1; tick(); rst = 1'b0;
        start_a = 1'b1; tick(); start_a = 1'b0;
        cnt = 0;
        while ({s2_a, s1_a, s0_a} != 3'd4 && cnt < 100) begin tick(); cnt++; end
        check("sel4_reached", {31'd0, (cnt < 100)}, 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("abort_sel",  {29'd0, s2_a, s1_a, s0_a}, 32'd0);
        check("abort_busy", {31'd0, busy_a}, 32'd0);
        check("abort_data", {24'd0, data_a}, 32'd0);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin tick(); if (valid_a) pulses++; end
        check("abort_no_valid", pulses, 32'd0);

        // start together with rst is discarded
        start_a = 1'b1; rst = 1'b1; tick(); start_a = 1'b0; rst = 1'b0;
        tick();
        check("start_in_rst", {31'd0, busy_a}, 32'd0);

        // DWELL=1, inputs 1,0,0,0,0,0,0,1 -> 8'h81 after 9 cycles
        mux_b = 8'h81;
        start_b = 1'b1; tick(); start_b = 1'b0;
        cnt = 0;
        while (!valid_b && cnt < 100) begin tick(); cnt++; end
        check("d1_latency", cnt, 32'd9);
        check("d1_data", {24'd0, data_b}, 32'h0000_0081);
`ifdef MUX_SCAN_PARITY_EN
        check("d1_parity0", {31'd0, par_b}, 32'd0);
`endif
        mux_b = 8'h01;
        start_b = 1'b1; tick(); start_b = 1'b0;
        cnt = 0;
        while (!valid_b && cnt < 100) begin tick(); cnt++; end
        check("d1_data01", {24'd0, data_b}, 32'h0000_0001);
`ifdef MUX_SCAN_PARITY_EN
        check("d1_parity1", {31'd0, par_b}, 32'd1);
`endif

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            start_a = ($urandom_range(0, 5) == 0);
            start_b = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 29) == 0) continuous = ~continuous;
            if ($urandom_range(0, 3) == 0) mux_a = 8'($urandom);
            if ($urandom_range(0, 3) == 0) mux_b = 8'($urandom);
            rst = ($urandom_range(0, 149) == 0);
            tick();
        end
        start_a = 1'b0; start_b = 1'b0; continuous = 1'b0; rst = 1'b0;
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
